// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer mux slice.
package bus_pkg;

   localparam int NUM_MASTERS = 4;
   localparam int GNT_W       = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } xfer_state_t;

   function automatic logic [NUM_MASTERS-1:0] gnt_onehot(input logic [GNT_W-1:0] g);
      gnt_onehot    = '0;
      gnt_onehot[g] = 1'b1;
   endfunction

endpackage

// File: rtl/bus_xfer_mux_if.sv
// Master-side and slave-side bus signals of the transfer mux.
// Modport "slave" is the mux's own view; "master" is the surrounding environment.
interface bus_xfer_mux_if
   import bus_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic                      comcyc;
   logic [GNT_W-1:0]          gnt;
   logic [NUM_MASTERS-1:0]    m_stb;
   logic [NUM_MASTERS-1:0]    m_we;
   logic [NUM_MASTERS*AW-1:0] m_adr;
   logic [NUM_MASTERS*DW-1:0] m_dat_w;
   logic [NUM_MASTERS-1:0]    m_ack;
   logic [NUM_MASTERS-1:0]    m_err;
   logic [DW-1:0]             m_dat_r;
   logic                      s_cyc;
   logic                      s_stb;
   logic                      s_we;
   logic [AW-1:0]             s_adr;
   logic [DW-1:0]             s_dat_w;
   logic [DW-1:0]             s_dat_r;
   logic                      s_ack;
   logic                      s_err;

   modport slave (
      input  comcyc, gnt, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_err,
      output m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w
   );

   modport master (
      output comcyc, gnt, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_err,
      input  m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w
   );
endinterface

// File: rtl/bus_timeout_cnt.sv
// Watchdog counter for the transfer mux; "expired" is high during the
// TIMEOUT-th consecutive enabled cycle since the last clear.
module bus_timeout_cnt #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 8'd1;
   end

   assign expired = en && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/bus_xfer_mux.sv
// Routes the granted master onto the shared slave and returns its response.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_xfer_mux
   import bus_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst_n,
   bus_xfer_mux_if.slave  bus
);
   xfer_state_t      state;
   logic [GNT_W-1:0] sel;
   logic             req;
   logic [AW-1:0]    adr_mux;
   logic [DW-1:0]    dat_mux;
   logic             we_mux;
   logic             wd_expired;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_xfer_mux: TIMEOUT must be in 1..255");
   end

   always_comb begin
      req     = bus.comcyc && bus.m_stb[bus.gnt];
      adr_mux = '0;
      dat_mux = '0;
      we_mux  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (bus.gnt == GNT_W'(i)) begin
            adr_mux = bus.m_adr[i*AW +: AW];
            dat_mux = bus.m_dat_w[i*DW +: DW];
            we_mux  = bus.m_we[i];
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   logic wd_clr;
   logic wd_en;

   // Held clear while idle so every WAIT starts counting from zero.
   assign wd_clr = (state == IDLE);
   assign wd_en  = (state == WAIT) && !bus.s_ack && !bus.s_err;

   bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel         <= '0;
         bus.s_cyc   <= 1'b0;
         bus.s_stb   <= 1'b0;
         bus.s_we    <= 1'b0;
         bus.s_adr   <= '0;
         bus.s_dat_w <= '0;
         bus.m_dat_r <= '0;
         bus.m_ack   <= '0;
         bus.m_err   <= '0;
      end else begin
         bus.s_cyc <= bus.comcyc;
         bus.m_ack <= '0;
         bus.m_err <= '0;
         case (state)
            IDLE: begin
               if (req) begin
                  sel         <= bus.gnt;
                  bus.s_adr   <= adr_mux;
                  bus.s_dat_w <= dat_mux;
                  bus.s_we    <= we_mux;
                  bus.s_stb   <= 1'b1;
                  state       <= WAIT;
               end
            end
            // Error beats ack, ack beats abort, abort beats the watchdog.
            WAIT: begin
               if (bus.s_err) begin
                  bus.m_err <= gnt_onehot(sel);
                  bus.s_stb <= 1'b0;
                  state     <= DONE;
               end else if (bus.s_ack) begin
                  bus.m_dat_r <= bus.s_dat_r;
                  bus.m_ack   <= gnt_onehot(sel);
                  bus.s_stb   <= 1'b0;
                  state       <= DONE;
               end else if (!bus.comcyc) begin
                  bus.s_stb <= 1'b0;
                  state     <= IDLE;
               end else if (wd_expired) begin
                  bus.m_err <= gnt_onehot(sel);
                  bus.s_stb <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_xfer_mux.sv
// Directed scoreboard bench for bus_xfer_mux; timeout steps follow BUS_TIMEOUT_EN.
module tb_bus_xfer_mux;
   import bus_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;
`ifdef BUS_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 15;
`endif

   typedef struct {
      logic [3:0]    ack;
      logic [3:0]    err;
      logic [DW-1:0] dat;
   } rsp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;
   rsp_t exp_q[$];
   logic [DW-1:0] last_dat;

   bus_xfer_mux_if #(.AW(AW), .DW(DW)) bus ();

   bus_xfer_mux #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_timeout: run exceeded its time limit");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic [3:0] ack, input logic [3:0] err, input logic [DW-1:0] dat);
      rsp_t r;
      r.ack = ack;
      r.err = err;
      r.dat = dat;
      exp_q.push_back(r);
   endtask

   // Response monitor: every ack/err pulse must match the oldest expectation.
   always @(negedge clk) begin
      if ((bus.m_ack | bus.m_err) != 4'd0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", {24'd0, bus.m_ack, bus.m_err}, 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_ack", 32'(bus.m_ack), 32'(e.ack));
            check("rsp_err", 32'(bus.m_err), 32'(e.err));
            check("rsp_dat", 32'(bus.m_dat_r), 32'(e.dat));
         end
      end
   end

   initial begin
      int bad_stb;
      int bad_err;

      // Reset with random inputs
      rst_n       = 1'b0;
      bus.comcyc  = 1'($urandom);
      bus.gnt     = 2'($urandom);
      bus.m_stb   = 4'($urandom);
      bus.m_we    = 4'($urandom);
      bus.m_adr   = {$urandom, $urandom};
      bus.m_dat_w = {$urandom, $urandom};
      bus.s_dat_r = 16'($urandom);
      bus.s_ack   = 1'($urandom);
      bus.s_err   = 1'($urandom);
      @(posedge clk);
      @(posedge clk);
      step();
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
      check("rst_s_stb", 32'(bus.s_stb), 32'd0);
      check("rst_s_we", 32'(bus.s_we), 32'd0);
      check("rst_s_adr", 32'(bus.s_adr), 32'd0);
      check("rst_s_dat_w", 32'(bus.s_dat_w), 32'd0);
      check("rst_m_dat_r", 32'(bus.m_dat_r), 32'd0);
      check("rst_m_ack_err", {24'd0, bus.m_ack, bus.m_err}, 32'd0);
      bus.comcyc = 1'b0; bus.gnt = 2'd0; bus.m_stb = 4'd0; bus.m_we = 4'd0;
      bus.s_ack = 1'b0; bus.s_err = 1'b0;
      last_dat = 16'h0000;
      rst_n = 1'b1;
      step();

      // Master 2 read, slave acks in its second WAIT cycle
      bus.comcyc = 1'b1;
      bus.gnt = 2'd2;
      bus.m_stb = 4'b0100;
      bus.m_we = 4'b1011;
      bus.m_adr[2*AW +: AW] = 16'h1234;
      push(4'b0100, 4'b0000, 16'hBEEF);
      step();
      check("m2_s_stb", 32'(bus.s_stb), 32'd1);
      check("m2_s_adr", 32'(bus.s_adr), 32'h1234);
      check("m2_s_we", 32'(bus.s_we), 32'd0);
      check("m2_s_cyc", 32'(bus.s_cyc), 32'd1);
      bus.gnt = 2'd1;
      step();
      check("m2_wait_stb", 32'(bus.s_stb), 32'd1);
      bus.s_ack = 1'b1;
      bus.s_dat_r = 16'hBEEF;
      step();
      bus.s_ack = 1'b0;
      bus.s_dat_r = 16'h0BAD;
      bus.m_stb = 4'b0000;
      check("m2_done_state", 32'(dut.state), 32'(DONE));
      check("m2_done_stb", 32'(bus.s_stb), 32'd0);
      last_dat = 16'hBEEF;
      step();
      check("m2_ack_one_cycle", 32'(bus.m_ack), 32'd0);
      check("m2_dat_hold", 32'(bus.m_dat_r), 32'hBEEF);
      check("m2_idle", 32'(dut.state), 32'(IDLE));

      // Master 1 write, ack and err together
      bus.gnt = 2'd1;
      bus.m_stb = 4'b0010;
      bus.m_we = 4'b0010;
      bus.m_adr[1*AW +: AW] = 16'h0042;
      bus.m_dat_w[1*DW +: DW] = 16'hA5A5;
      push(4'b0000, 4'b0010, last_dat);
      step();
      check("m1_s_we", 32'(bus.s_we), 32'd1);
      check("m1_s_dat_w", 32'(bus.s_dat_w), 32'hA5A5);
      check("m1_s_adr", 32'(bus.s_adr), 32'h0042);
      bus.s_ack = 1'b1;
      bus.s_err = 1'b1;
      bus.s_dat_r = 16'h1111;
      step();
      bus.s_ack = 1'b0;
      bus.s_err = 1'b0;
      bus.m_stb = 4'b0000;
      bus.m_we = 4'b0000;
      step();

      // Master 0 back-to-back, slave acks in its first cycle
      bus.gnt = 2'd0;
      bus.m_stb = 4'b0001;
      bus.m_adr[0 +: AW] = 16'h0100;
      push(4'b0001, 4'b0000, 16'h0001);
      step();
      check("b2b_first_stb", 32'(bus.s_stb), 32'd1);
      bus.s_ack = 1'b1;
      bus.s_dat_r = 16'h0001;
      step();
      bus.s_ack = 1'b0;
      bus.m_adr[0 +: AW] = 16'h0101;
      push(4'b0001, 4'b0000, 16'h0002);
      check("b2b_done_stb", 32'(bus.s_stb), 32'd0);
      step();
      check("b2b_turnaround_stb", 32'(bus.s_stb), 32'd0);
      check("b2b_turnaround_idle", 32'(dut.state), 32'(IDLE));
      step();
      check("b2b_second_stb", 32'(bus.s_stb), 32'd1);
      check("b2b_second_adr", 32'(bus.s_adr), 32'h0101);
      bus.s_ack = 1'b1;
      bus.s_dat_r = 16'h0002;
      step();
      bus.s_ack = 1'b0;
      bus.m_stb = 4'b0000;
      last_dat = 16'h0002;
      step();

      // Abort: comcyc drops during WAIT
      bus.gnt = 2'd3;
      bus.m_stb = 4'b1000;
      bus.m_adr[3*AW +: AW] = 16'h0777;
      step();
      check("abort_wait_stb", 32'(bus.s_stb), 32'd1);
      bus.comcyc = 1'b0;
      step();
      check("abort_s_stb", 32'(bus.s_stb), 32'd0);
      check("abort_state", 32'(dut.state), 32'(IDLE));
      check("abort_no_rsp", {24'd0, bus.m_ack, bus.m_err}, 32'd0);
      check("abort_s_cyc", 32'(bus.s_cyc), 32'd0);
      step();
      check("abort_no_restart", 32'(bus.s_stb), 32'd0);
      bus.m_stb = 4'b0000;
      bus.comcyc = 1'b1;
      step();

`ifdef BUS_TIMEOUT_EN
      // Watchdog expiry with no response
      bus.gnt = 2'd0;
      bus.m_stb = 4'b0001;
      bus.m_adr[0 +: AW] = 16'h0200;
      push(4'b0000, 4'b0001, last_dat);
      step();
      for (int i = 1; i <= TO; i++) begin
         check("wd_stb_hold", 32'(bus.s_stb), 32'd1);
         check("wd_no_early_err", 32'(bus.m_err), 32'd0);
         if (i < TO) step();
      end
      step();
      check("wd_err_pulse", 32'(bus.m_err), 32'b0001);
      bus.m_stb = 4'b0000;
      step();
      // Ack arriving in the expiry cycle wins
      bus.m_stb = 4'b0001;
      push(4'b0001, 4'b0000, 16'h5A5A);
      step();
      for (int i = 1; i <= TO; i++) begin
         if (i == TO) begin
            bus.s_ack = 1'b1;
            bus.s_dat_r = 16'h5A5A;
         end else begin
            step();
         end
      end
      step();
      check("wd_ack_wins", {24'd0, bus.m_ack, bus.m_err}, 32'h10);
      bus.s_ack = 1'b0;
      bus.m_stb = 4'b0000;
      last_dat = 16'h5A5A;
      step();
`else
      // No watchdog: slave silent for 300 cycles
      bus.gnt = 2'd0;
      bus.m_stb = 4'b0001;
      bus.m_adr[0 +: AW] = 16'h0300;
      push(4'b0001, 4'b0000, 16'h3C3C);
      step();
      bad_stb = 0;
      bad_err = 0;
      for (int i = 0; i < 300; i++) begin
         if (bus.s_stb !== 1'b1) bad_stb++;
         if (bus.m_err !== 4'd0) bad_err++;
         step();
      end
      check("hang_stb_low_cycles", 32'(bad_stb), 32'd0);
      check("hang_err_cycles", 32'(bad_err), 32'd0);
      bus.s_ack = 1'b1;
      bus.s_dat_r = 16'h3C3C;
      step();
      bus.s_ack = 1'b0;
      bus.m_stb = 4'b0000;
      last_dat = 16'h3C3C;
      step();
`endif

      // Reset in the middle of WAIT, with a slave ack on the same edge
      bus.gnt = 2'd2;
      bus.m_stb = 4'b0100;
      bus.m_adr[2*AW +: AW] = 16'h0ABC;
      step();
      check("rw_wait_stb", 32'(bus.s_stb), 32'd1);
      rst_n = 1'b0;
      bus.s_ack = 1'b1;
      bus.s_dat_r = 16'h7777;
      step();
      check("rw_state", 32'(dut.state), 32'(IDLE));
      check("rw_s_stb", 32'(bus.s_stb), 32'd0);
      check("rw_no_rsp", {24'd0, bus.m_ack, bus.m_err}, 32'd0);
      check("rw_m_dat_r", 32'(bus.m_dat_r), 32'd0);
      check("rw_s_adr", 32'(bus.s_adr), 32'd0);
      bus.s_ack = 1'b0;
      bus.m_stb = 4'b0000;
      rst_n = 1'b1;
      step();
      step();

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/bus_xfer_mux.md
# bus_xfer_mux

Downstream data-path stage of the 4-master round-robin arbiter. It consumes the arbiter's `comcyc` and encoded `gnt[1:0]`, routes the granted master's strobe, address, write data and direction to the single shared slave, and returns the slave's read data, acknowledge and error to that master. A small FSM registers each transfer and guarantees one slave access per master strobe. An optional watchdog terminates transfers the slave never acknowledges.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `TIMEOUT`, 15, wait cycles before watchdog error (1..255)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `comcyc`  in  1  bus owned (from arbiter)
- `gnt`  in  2  encoded grant index (from arbiter)
- `m_stb`  in  4  per-master transfer strobe
- `m_we`  in  4  per-master write enable
- `m_adr`  in  4*AW  per-master address, master i at [i*AW +: AW]
- `m_dat_w`  in  4*DW  per-master write data, same packing
- `m_ack`  out  4  per-master acknowledge pulse
- `m_err`  out  4  per-master error pulse
- `m_dat_r`  out  DW  read data, broadcast to all masters
- `s_cyc`  out  1  slave cycle
- `s_stb`  out  1  slave strobe
- `s_we`  out  1  slave write enable
- `s_adr`  out  AW  slave address
- `s_dat_w`  out  DW  slave write data
- `s_dat_r`  in  DW  slave read data
- `s_ack`  in  1  slave acknowledge
- `s_err`  in  1  slave error

## Operation
- FSM states:
  - IDLE
  - WAIT
  - DONE
- IDLE:
  - If `comcyc`=1 and `m_stb[gnt]`=1, latch `gnt` into `sel`, and latch `m_adr`/`m_dat_w`/`m_we` of master `gnt` into `s_adr`/`s_dat_w`/`s_we`.
  - Then set `s_stb`=1 and go to WAIT.
- WAIT:
  - `s_stb` stays 1.
  - `s_err`=1: `m_err[sel]` pulses, then DONE. `s_err` has priority over `s_ack`.
  - `s_ack`=1 (and `s_err`=0): `m_dat_r` <= `s_dat_r`, `m_ack[sel]` pulses, then DONE.
  - `comcyc` drops: abort. `s_stb`<=0, go to IDLE, no ack or err.
  - Watchdog expires (see Configuration): `m_err[sel]` pulses, then DONE.
- DONE:
  - One turnaround cycle with `s_stb`=0, then IDLE.
  - The master uses this cycle to drop or change its strobe. This prevents a duplicate access.
- `gnt` changes while in WAIT or DONE are ignored; `sel` is used.
- `s_cyc` is registered `comcyc`.
- `m_dat_r` holds its last captured value until the next `s_ack`.
- At most one bit of `m_ack | m_err` is set in any cycle.

## Timing
- Reset values:
  - FSM = IDLE; `sel`=0.
  - `s_cyc`, `s_stb`, `s_we` = 0.
  - `s_adr`, `s_dat_w`, `m_dat_r` = 0.
  - `m_ack`, `m_err` = 0.
  - Watchdog count = 0.
- Reset mid-WAIT: all of the above apply on the next edge; no ack or err is issued.
- Request sampled at edge N → `s_stb`=1 from N+1.
- `s_ack` sampled at edge K → `m_ack[sel]`=1 and `m_dat_r` valid in cycle K+1, for exactly 1 cycle.
- Minimum turnaround: request → ack is 3 cycles when the slave acks in its first cycle.
- Back-to-back transfers from the same master: one transfer per 3 cycles minimum.
- `s_ack` and watchdog expiry in the same cycle: ack wins.
- `s_err` and watchdog expiry in the same cycle: a single `m_err` pulse.

## Configuration
- Macro `BUS_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without a response.
  - When the count equals `TIMEOUT`, `m_err[sel]` pulses and the FSM goes to DONE.
- Undefined:
  - No counter is built and `TIMEOUT` is unused.
  - WAIT is left only by `s_ack`, `s_err`, abort or reset.

## Structure
- Shared package `bus_pkg`:
  - State enum `xfer_state_t` (IDLE, WAIT, DONE).
  - Constant `NUM_MASTERS`=4.
  - Grant index width constant = 2.
- Sub-module `bus_timeout_cnt`:
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Output: `expired`.
  - Instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 for 2 edges with random inputs.
  - Required: all outputs 0, FSM IDLE.
- Master 2 read:
  - Stimulus: `comcyc`=1, `gnt`=2, `m_stb[2]`=1, `m_adr[2]`=0x1234, `m_we[2]`=0; slave acks after 2 cycles with 0xBEEF.
  - Required: `s_adr`=0x1234; `m_ack`=4'b0100 for 1 cycle with `m_dat_r`=0xBEEF; `s_stb` low in DONE.
- Master 1 write:
  - Stimulus: `m_dat_w[1]`=0xA5A5, `m_we[1]`=1; `s_ack` and `s_err` asserted together.
  - Required: `s_we`=1, `s_dat_w`=0xA5A5; `m_err`=4'b0010; `m_ack`=0.
- Abort:
  - Stimulus: drop `comcyc` in WAIT.
  - Required: `s_stb`=0 next cycle; no `m_ack` or `m_err`; FSM IDLE.
- Timeout, `BUS_TIMEOUT_EN` defined:
  - Stimulus: `TIMEOUT`=4, slave never acks.
  - Required: `m_err[sel]` pulses after 4 WAIT cycles.
  - Also: ack arriving in the expiry cycle gives `m_ack` and no `m_err`.
- Timeout, `BUS_TIMEOUT_EN` undefined:
  - Stimulus: slave never acks for 300 cycles.
  - Required: `s_stb` stays 1, no `m_err`.
